control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multi-cycle controller for a 4-register, 8-bit accumulator datapath.
// Ports: clk, rst (sync active-low), instruction, zero -> load/select/write strobes, halted.
module control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4,
  parameter int Sel1_size  = 3,
  parameter int Sel2_size  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 write,
  output logic                 halted
);

  typedef enum logic [state_size-1:0] {
    S_idle = 0,
    S_fet1 = 1,
    S_fet2 = 2,
    S_dec  = 3,
    S_ex1  = 4,
    S_rd1  = 5,
    S_rd2  = 6,
    S_wr1  = 7,
    S_wr2  = 8,
    S_br1  = 9,
    S_br2  = 10,
    S_halt = 11
  } state_t;

  localparam logic [op_size-1:0] OP_NOP = op_size'(0);
  localparam logic [op_size-1:0] OP_ADD = op_size'(1);
  localparam logic [op_size-1:0] OP_SUB = op_size'(2);
  localparam logic [op_size-1:0] OP_AND = op_size'(3);
  localparam logic [op_size-1:0] OP_NOT = op_size'(4);
  localparam logic [op_size-1:0] OP_RD  = op_size'(5);
  localparam logic [op_size-1:0] OP_WR  = op_size'(6);
  localparam logic [op_size-1:0] OP_BR  = op_size'(7);
  localparam logic [op_size-1:0] OP_BRZ = op_size'(8);

  localparam logic [Sel1_size-1:0] SEL1_PC   = Sel1_size'(4);
  localparam logic [Sel2_size-1:0] SEL2_ALU  = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] SEL2_BUS1 = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] SEL2_MEM  = Sel2_size'(2);

  state_t             state;
  logic [op_size-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;
  logic [3:0]         load_r;
  logic               brz_taken;

  assign opcode    = instruction[op_size+3:4];
  assign src       = instruction[3:2];
  assign dest      = instruction[1:0];
  assign brz_taken = zero;

  assign Load_R0 = load_r[0];
  assign Load_R1 = load_r[1];
  assign Load_R2 = load_r[2];
  assign Load_R3 = load_r[3];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_idle;
    end else begin
      case (state)
        S_idle: state <= S_fet1;
        S_fet1: state <= S_fet2;
        S_fet2: state <= S_dec;
        S_dec: begin
          case (opcode)
            OP_NOP: state <= S_fet1;
            OP_ADD,
            OP_SUB,
            OP_AND: state <= S_ex1;
            OP_NOT: state <= S_fet1;
            OP_RD:  state <= S_rd1;
            OP_WR:  state <= S_wr1;
            OP_BR:  state <= S_br1;
            OP_BRZ: state <= brz_taken ? S_br1 : S_fet1;
            default: state <= S_halt;
          endcase
        end
        S_ex1:  state <= S_fet1;
        S_rd1:  state <= S_rd2;
        S_rd2:  state <= S_fet1;
        S_wr1:  state <= S_wr2;
        S_wr2:  state <= S_fet1;
        S_br1:  state <= S_br2;
        S_br2:  state <= S_fet1;
        S_halt: state <= S_halt;
        default: state <= S_idle;
      endcase
    end
  end

  // Outputs are held low while reset is asserted so that an
  // in-flight store or register load cannot fire during reset.
  always_comb begin
    load_r        = 4'b0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    Sel_Bus_1_Mux = '0;
    Sel_Bus_2_Mux = '0;
    write         = 1'b0;
    halted        = 1'b0;
    if (rst) begin
      case (state)
        S_fet1: begin
          Sel_Bus_1_Mux = SEL1_PC;
          Sel_Bus_2_Mux = SEL2_BUS1;
          Load_Add_R    = 1'b1;
        end
        S_fet2: begin
          Sel_Bus_2_Mux = SEL2_MEM;
          Load_IR       = 1'b1;
          Inc_PC        = 1'b1;
        end
        S_dec: begin
          case (opcode)
            OP_ADD,
            OP_SUB,
            OP_AND: begin
              Sel_Bus_1_Mux = Sel1_size'(src);
              Sel_Bus_2_Mux = SEL2_BUS1;
              Load_Reg_Y    = 1'b1;
            end
            OP_NOT: begin
              Sel_Bus_1_Mux = Sel1_size'(src);
              Sel_Bus_2_Mux = SEL2_ALU;
              Load_Reg_Z    = 1'b1;
              load_r[dest]  = 1'b1;
            end
            OP_RD,
            OP_WR,
            OP_BR: begin
              Sel_Bus_1_Mux = SEL1_PC;
              Sel_Bus_2_Mux = SEL2_BUS1;
              Load_Add_R    = 1'b1;
            end
            OP_BRZ: begin
              if (brz_taken) begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_BUS1;
                Load_Add_R    = 1'b1;
              end else begin
                // Step over the unused branch-target byte.
                Inc_PC = 1'b1;
              end
            end
            default: ;
          endcase
        end
        S_ex1: begin
          Sel_Bus_1_Mux = Sel1_size'(dest);
          Sel_Bus_2_Mux = SEL2_ALU;
          Load_Reg_Z    = 1'b1;
          load_r[dest]  = 1'b1;
        end
        S_rd1,
        S_wr1: begin
          Sel_Bus_2_Mux = SEL2_MEM;
          Load_Add_R    = 1'b1;
          Inc_PC        = 1'b1;
        end
        S_rd2: begin
          Sel_Bus_2_Mux = SEL2_MEM;
          load_r[dest]  = 1'b1;
        end
        S_wr2: begin
          Sel_Bus_1_Mux = Sel1_size'(src);
          write         = 1'b1;
        end
        S_br1: begin
          Sel_Bus_2_Mux = SEL2_MEM;
          Load_Add_R    = 1'b1;
        end
        S_br2: begin
          Sel_Bus_2_Mux = SEL2_MEM;
          Load_PC       = 1'b1;
        end
        S_halt: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
